dcache: RTL and testbench
=========================

// Module: dcache
// PURPOSE
//  Responder end of the CPU data-memory handshake: the CPU presents address/read/write/byte_enable,
//  holds them until mem_resp. This block answers that handshake.
//  Direct-mapped, write-back, write-allocate L1 data cache in front of a 128-bit line-wide physical memory.
//  Hits complete in the request cycle (zero wait states); misses stall the CPU via mem_resp=0.
// PARAMETERS
//  INDEX_BITS  3  log2(number of sets); 8 lines x 16 bytes; tag width = 12 - INDEX_BITS (9)
// PORTS
//  clk              in   1    clock, all state on rising edge
//  rst_n            in   1    synchronous active-low reset
//  dcache_enable    in   1    request qualifier from CPU; 0 = no request this cycle
//  mem_address      in   16   byte address: [15:4+INDEX_BITS] tag, [3+INDEX_BITS:4] index, [3:1] word, [0] byte
//  mem_read         in   1    read request
//  mem_write        in   1    write request
//  mem_byte_enable  in   2    write byte lanes: [1] = high byte, [0] = low byte
//  mem_wdata        in   16   write data
//  mem_rdata        out  16   read data; valid when mem_resp=1
//  mem_resp         out  1    request complete (combinational on hit)
//  dcache_hit       out  1    tag match on a valid line this cycle
//  pmem_address     out  16   line address, bits [3:0] = 0
//  pmem_read        out  1    line fill request, held until pmem_resp
//  pmem_write       out  1    line writeback request, held until pmem_resp
//  pmem_wdata       out  128  victim line data
//  pmem_rdata       in   128  fill line data; valid with pmem_resp
//  pmem_resp        in   1    pmem transaction complete, single-cycle pulse
// BEHAVIOUR
//  Request condition: req = dcache_enable & (mem_read | mem_write).
//  - Read and write both high is treated as a write.
//  Reset (rst_n=0 at edge):
//  - all valid and dirty bits cleared; state = IDLE.
//  - Next cycle: mem_resp=0, dcache_hit=0, pmem_read=0, pmem_write=0, pmem_address=0, mem_rdata=0.
//  - Reset mid-WRITEBACK/FILL abandons the transaction; victim dirty data is lost (accepted).
//  FSM states: IDLE, WRITEBACK, FILL.
//  IDLE:
//  - hit = req & valid[idx] & (tag[idx] == addr tag). dcache_hit = hit; mem_resp = hit, same cycle.
//  - Read hit: mem_rdata = line word [3:1], combinational.
//  - Write hit: at the edge, merge only the enabled bytes into the word and set dirty[idx].
//  - be=00 changes no data but still sets dirty.
//  - req & !hit & dirty[idx] -> WRITEBACK. req & !hit & !dirty[idx] -> FILL. No req: stay, no pmem activity.
//  WRITEBACK:
//  - pmem_write=1, pmem_address = {stored tag, idx, 4'b0}, pmem_wdata = stored line.
//  - On pmem_resp: clear dirty[idx], go to FILL.
//  FILL:
//  - pmem_read=1, pmem_address = {req tag, idx, 4'b0}.
//  - On pmem_resp: write pmem_rdata into line, tag <= req tag, valid=1, dirty=0, go to IDLE.
//  - The next cycle re-evaluates as a hit.
//  Latency:
//  - hit = 0 extra cycles.
//  - clean miss = Lfill + 1 cycles.
//  - dirty miss = Lwb + Lfill + 1 cycles, where L* = cycles to pmem_resp.
//  mem_resp is never asserted outside IDLE. pmem_read and pmem_write are never high together.
//  Request withdrawn mid-miss (CPU flush): the current pmem transaction completes and the line installs.
//  - FSM returns to IDLE; no mem_resp is issued.
//  CPU inputs must stay stable while mem_resp=0. The index used in WRITEBACK/FILL is taken live from mem_address.
// STRUCTURE
//  Package lc3b_types gains:
//  - lc3b_cache_line (logic [127:0]), lc3b_cache_tag, lc3b_cache_index, lc3b_cache_offset.
//  - dcache_state_t enum {IDLE, WRITEBACK, FILL}.
//  Sub-module dcache_array holds data, tag, valid and dirty.
//  - async read by index; sync write with per-byte line write mask; sync clear on rst_n.
//  FSM, hit compare, byte merge and pmem address muxing stay in dcache.
// TESTING
//  1. Reset, then read 0x0012 -> FILL with pmem_address=0x0010.
//     Return line with word1=0xBEEF -> mem_resp one cycle after pmem_resp, mem_rdata=0xBEEF.
//  2. Read 0x0014 after test 1 -> mem_resp and dcache_hit in the request cycle; pmem_read and pmem_write stay 0.
//  3. Write 0x0013, be=10, wdata=0xAB00 -> mem_resp same cycle; a later read of 0x0012 returns 0xABEF.
//  4. Read 0x0090 (same index 1, tag 1):
//     -> WRITEBACK at 0x0010 with pmem_wdata word1=0xABEF, then FILL at 0x0090, then mem_resp.
//  5. Drop dcache_enable during FILL -> fill completes and the line becomes valid.
//     mem_resp stays 0; re-issuing the request hits immediately.
//  6. rst_n=0 for one cycle during FILL -> pmem_read=0 next cycle.
//     A read of the same address misses again (all lines invalid).

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared cache types: line/tag/index/offset widths, the miss-handling state enum,
// and the byte-lane mask helper used by write hits.
package lc3b_types;

    localparam int INDEX_BITS = 3;
    localparam int TAG_BITS   = 12 - INDEX_BITS;
    localparam int NUM_SETS   = 1 << INDEX_BITS;

    typedef logic [127:0]          lc3b_cache_line;
    typedef logic [TAG_BITS-1:0]   lc3b_cache_tag;
    typedef logic [INDEX_BITS-1:0] lc3b_cache_index;
    typedef logic [2:0]            lc3b_cache_offset;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} dcache_state_t;

    // Places the two CPU byte enables onto the 16 byte lanes of a line.
    function automatic logic [15:0] word_byte_mask(lc3b_cache_offset word, logic [1:0] be);
        logic [15:0] mask;
        mask = '0;
        mask[{word, 1'b0} +: 2] = be;
        return mask;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Storage for the direct-mapped cache: line data, tags, valid and dirty bits.
// Reads are asynchronous by index; writes are per-byte on the line plus per-field enables.
module dcache_array
    import lc3b_types::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] i_index,
    input  logic [15:0]           i_byte_we,
    input  logic [127:0]          i_wdata,
    input  logic                  i_tag_we,
    input  logic [TAG_BITS-1:0]   i_wtag,
    input  logic                  i_valid_we,
    input  logic                  i_valid,
    input  logic                  i_dirty_we,
    input  logic                  i_dirty,
    output logic [127:0]          o_line,
    output logic [TAG_BITS-1:0]   o_tag,
    output logic                  o_valid,
    output logic                  o_dirty
);

    lc3b_cache_line        r_data [NUM_SETS];
    lc3b_cache_tag         r_tag  [NUM_SETS];
    logic [NUM_SETS-1:0]   r_valid;
    logic [NUM_SETS-1:0]   r_dirty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_valid_we) r_valid[i_index] <= i_valid;
            if (i_dirty_we) r_dirty[i_index] <= i_dirty;
        end
    end

    // Data and tags need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 16; b++) begin
            if (i_byte_we[b]) r_data[i_index][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
        if (i_tag_we) r_tag[i_index] <= i_wtag;
    end

    assign o_line  = r_data[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate L1 data cache; zero-wait hits,
// misses stall the CPU while the FSM writes back the victim and fills the line.
//
//   state     | meaning
//   IDLE      | serve hits combinationally, detect misses
//   WRITEBACK | push dirty victim line to pmem
//   FILL      | fetch requested line from pmem and install it
module dcache
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         dcache_enable,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         dcache_hit,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    dcache_state_t r_state;
    dcache_state_t w_next;

    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_index;
    logic [2:0]            w_word;
    logic                  w_req;
    logic                  w_hit;

    logic [127:0]          w_line;
    logic [TAG_BITS-1:0]   w_stored_tag;
    logic                  w_valid;
    logic                  w_dirty;

    logic [15:0]           w_byte_we;
    logic [127:0]          w_wdata;
    logic                  w_tag_we;
    logic                  w_valid_we;
    logic                  w_valid_in;
    logic                  w_dirty_we;
    logic                  w_dirty_in;

    assign w_tag   = mem_address[15:4+INDEX_BITS];
    assign w_index = mem_address[3+INDEX_BITS:4];
    assign w_word  = mem_address[3:1];
    assign w_req   = dcache_enable & (mem_read | mem_write);
    assign w_hit   = w_req & w_valid & (w_stored_tag == w_tag);

    dcache_array u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_index    (w_index),
        .i_byte_we  (w_byte_we),
        .i_wdata    (w_wdata),
        .i_tag_we   (w_tag_we),
        .i_wtag     (w_tag),
        .i_valid_we (w_valid_we),
        .i_valid    (w_valid_in),
        .i_dirty_we (w_dirty_we),
        .i_dirty    (w_dirty_in),
        .o_line     (w_line),
        .o_tag      (w_stored_tag),
        .o_valid    (w_valid),
        .o_dirty    (w_dirty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_req && !w_hit) w_next = w_dirty ? WRITEBACK : FILL;
            WRITEBACK: if (pmem_resp) w_next = FILL;
            FILL:      if (pmem_resp) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_resp     = 1'b0;
        dcache_hit   = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        w_byte_we    = '0;
        w_wdata      = '0;
        w_tag_we     = 1'b0;
        w_valid_we   = 1'b0;
        w_valid_in   = 1'b0;
        w_dirty_we   = 1'b0;
        w_dirty_in   = 1'b0;
        case (r_state)
            IDLE: begin
                dcache_hit = w_hit;
                mem_resp   = w_hit;
                // Read+write together counts as a write.
                if (w_hit && mem_write) begin
                    w_byte_we  = word_byte_mask(w_word, mem_byte_enable);
                    w_wdata    = {8{mem_wdata}};
                    w_dirty_we = 1'b1;
                    w_dirty_in = 1'b1;
                end else if (w_hit) begin
                    mem_rdata = w_line[{w_word, 4'b0} +: 16];
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {w_stored_tag, w_index, 4'b0};
                pmem_wdata   = w_line;
                if (pmem_resp) w_dirty_we = 1'b1;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {w_tag, w_index, 4'b0};
                if (pmem_resp) begin
                    w_byte_we  = '1;
                    w_wdata    = pmem_rdata;
                    w_tag_we   = 1'b1;
                    w_valid_we = 1'b1;
                    w_valid_in = 1'b1;
                    w_dirty_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache.sv
// Randomized bench for dcache: a flat byte-memory model (what the CPU should see)
// plus a pmem backing store and residency bookkeeping predict hits, writebacks and latency.
module tb_dcache;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         dcache_enable = 1'b0;
    logic [15:0]  mem_address = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [1:0]   mem_byte_enable = '0;
    logic [15:0]  mem_wdata = '0;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         dcache_hit;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    dcache dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dcache_enable   (dcache_enable),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .dcache_hit      (dcache_hit),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Addresses stay below 0x200: 32 lines, tags 0..3, so set conflicts are frequent.
    logic [7:0]   gold [512];
    logic [127:0] back [32];
    logic [8:0]   mtag [8];
    bit           mvalid [8];
    bit           mdirty [8];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] gold_line(input int ln);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[b*8 +: 8] = gold[ln*16 + b];
        return r;
    endfunction

    task automatic sync_gold_to_back();
        for (int l = 0; l < 32; l++)
            for (int b = 0; b < 16; b++) gold[l*16 + b] = back[l][b*8 +: 8];
    endtask

    // mode 0: normal, 1: drop enable once FILL starts, 2: pulse reset once FILL starts
    task automatic do_req(input logic [15:0] a, input bit wr, input logic [1:0] be,
                          input logic [15:0] wd, input int mode);
        int   idx = int'(a[6:4]);
        int   ln = int'(a[8:4]);
        bit   exp_hit = mvalid[idx] && (mtag[idx] == a[15:7]);
        int   vline = int'(mtag[idx]) * 8 + idx;
        int   waits = 0;
        int   exp_waits = exp_hit ? 0 : 1;
        int   lat = 0;
        bit   done = 0, wb_seen = 0, fill_seen = 0, fill_done = 0, flushed = 0;
        mem_address     = a;
        mem_write       = wr;
        mem_read        = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_byte_enable = be;
        mem_wdata       = wd;
        dcache_enable   = 1'b1;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            if (cyc == 0) check_eq("hit_first_cycle", dcache_hit, exp_hit);
            check_eq("pmem_exclusive", pmem_read & pmem_write, 1'b0);
            if (flushed) check_eq("flush_no_resp", mem_resp, 1'b0);
            if (mem_resp) begin
                if (!flushed) begin
                    check_eq("miss_latency", waits, exp_waits);
                    if (!wr) check_eq("rdata", mem_rdata, {gold[a | 16'h1], gold[a & 16'hFFFE]});
                    else begin
                        if (be[0]) gold[a & 16'hFFFE] = wd[7:0];
                        if (be[1]) gold[a | 16'h1]    = wd[15:8];
                        mdirty[idx] = 1;
                    end
                end
                done = 1;
            end else begin
                waits++;
                if (pmem_write) begin
                    if (!wb_seen) begin
                        wb_seen = 1;
                        check_eq("wb_expected", exp_hit == 0 && mdirty[idx], 1'b1);
                        check_eq("wb_address", pmem_address, 16'(vline * 16));
                        check_eq("wb_data", pmem_wdata, gold_line(vline));
                        lat = $urandom_range(1, 4);
                        exp_waits += lat;
                    end
                    lat--;
                    if (lat == 0) begin
                        back[vline] = pmem_wdata;
                        mdirty[idx] = 0;
                        pmem_resp = 1'b1;
                    end
                end else if (pmem_read) begin
                    if (!fill_seen) begin
                        fill_seen = 1;
                        check_eq("fill_wb_done", mvalid[idx] && mdirty[idx], 1'b0);
                        check_eq("fill_address", pmem_address, a & 16'hFFF0);
                        lat = $urandom_range(1, 4);
                        exp_waits += lat;
                    end
                    if (mode != 2) begin
                        lat--;
                        if (lat == 0) begin
                            pmem_rdata  = back[ln];
                            mvalid[idx] = 1;
                            mdirty[idx] = 0;
                            mtag[idx]   = a[15:7];
                            fill_done   = 1;
                            pmem_resp   = 1'b1;
                        end
                    end
                end else if (fill_done) begin
                    done = 1;
                end
            end
            if (mode == 2 && fill_seen) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                check_eq("rst_pmem_read", pmem_read, 1'b0);
                check_eq("rst_pmem_write", pmem_write, 1'b0);
                check_eq("rst_mem_resp", mem_resp, 1'b0);
                check_eq("rst_hit", dcache_hit, 1'b0);
                check_eq("rst_pmem_address", pmem_address, 16'h0);
                check_eq("rst_rdata", mem_rdata, 16'h0);
                @(negedge clk);
                rst_n = 1'b1;
                dcache_enable = 1'b0;
                for (int s = 0; s < 8; s++) begin mvalid[s] = 0; mdirty[s] = 0; end
                sync_gold_to_back();
                done = 1;
            end else begin
                if (mode == 1 && fill_seen && !flushed) begin
                    dcache_enable = 1'b0;
                    flushed = 1;
                end
                @(posedge clk);
                @(negedge clk);
                pmem_resp = 1'b0;
            end
        end
        check_eq("req_timeout", done, 1'b1);
        dcache_enable = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] a;
        for (int l = 0; l < 32; l++) back[l] = {$urandom, $urandom, $urandom, $urandom};
        back[1][31:16] = 16'hBEEF;
        sync_gold_to_back();
        for (int s = 0; s < 8; s++) begin mvalid[s] = 0; mdirty[s] = 0; mtag[s] = '0; end

        repeat (2) @(negedge clk);
        check_eq("reset_mem_resp", mem_resp, 1'b0);
        check_eq("reset_pmem_read", pmem_read, 1'b0);
        check_eq("reset_pmem_write", pmem_write, 1'b0);
        check_eq("reset_pmem_address", pmem_address, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(16'h0012, 0, 2'b00, 16'h0, 0);
        check_eq("beef_word", gold[16'h13], 8'hBE);
        do_req(16'h0014, 0, 2'b00, 16'h0, 0);
        do_req(16'h0013, 1, 2'b10, 16'hAB00, 0);
        do_req(16'h0012, 0, 2'b00, 16'h0, 0);
        check_eq("merged_word", {gold[16'h13], gold[16'h12]}, 16'hABEF);
        do_req(16'h0090, 0, 2'b00, 16'h0, 0);
        do_req(16'h0110, 0, 2'b00, 16'h0, 1);
        do_req(16'h0110, 0, 2'b00, 16'h0, 0);

        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom_range(0, 511));
            if (i == 150) begin
                do_req(a, 0, 2'b00, 16'h0, 2);
                do_req(a, 0, 2'b00, 16'h0, 0);
            end else if ($urandom_range(0, 15) == 0) begin
                do_req(a, 0, 2'b00, 16'h0, 1);
                do_req(a, 0, 2'b00, 16'h0, 0);
            end else begin
                do_req(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
